// File: rtl/mul_share_arbiter.sv
// Purpose: generic FIFO holding tagged products until the consumer takes them.
// Latency: a push is visible at rdata/empty the cycle after the push edge.
// Backpressure: caller must not push while full unless popping in the same cycle.
module msa_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  // Extra pointer MSB tells full from empty when the indices coincide.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)          wptr <= wptr + PTR_ONE;
      if (pop && !empty) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) assert (!full);
  end
endmodule

// Purpose: round-robin sharing of one external pipelined multiplier among NUM_REQ requesters.
// Latency: accept at edge 0, product pushed at edge MUL_LAT+1, rsp_valid high right after.
// Backpressure: grants stop once FIFO_DEPTH results are outstanding; no rsp_ready->req_ready path.
module mul_share_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  WIDTH      = 16,
  parameter int  MUL_LAT    = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_issue,
  input  logic [WIDTH-1:0]         mul_p,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] dat;
  } rsp_t;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             run;
  logic             credit_ok;
  logic             acc_vld;
  logic             pop_vld;
  logic             push_vld;
  logic [CNT_W-1:0] outstanding;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [MUL_LAT:0] tag_vld;
  logic [ID_W-1:0]  tag_id [MUL_LAT+1];
  rsp_t             push_dat;
  rsp_t             head_dat;
  logic             fifo_empty;
  logic             fifo_full;

  // Searching from the far end lets the nearest requester after rr_ptr win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // run holds grants off until the first edge after reset release.
  assign credit_ok = run && (outstanding < CNT_FULL);
  assign acc_vld   = gnt_vld && credit_ok;

  always_comb begin
    req_ready = '0;
    if (acc_vld) req_ready[gnt_id] = 1'b1;
  end

  assign sel_a = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(gnt_id)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      mul_a     <= '0;
      mul_b     <= '0;
      mul_issue <= 1'b0;
    end else begin
      run       <= 1'b1;
      mul_issue <= acc_vld;
      if (acc_vld) begin
        rr_ptr <= gnt_id;
        mul_a  <= sel_a;
        mul_b  <= sel_b;
      end
    end
  end

  // Stage 0 lines up with mul_a/mul_b; stage MUL_LAT lines up with mul_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i <= MUL_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld   <= {tag_vld[MUL_LAT-1:0], acc_vld};
      tag_id[0] <= gnt_id;
      for (int i = 1; i <= MUL_LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  assign push_vld = tag_vld[MUL_LAT];
  assign pop_vld  = rsp_valid && rsp_ready;
  assign push_dat = '{id: tag_id[MUL_LAT], dat: mul_p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (acc_vld && !pop_vld) begin
      outstanding <= outstanding + CNT_ONE;
    end else if (!acc_vld && pop_vld) begin
      outstanding <= outstanding - CNT_ONE;
    end
  end

  msa_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_vld),
    .wdata (push_dat),
    .pop   (pop_vld),
    .rdata (head_dat),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = rsp_valid ? head_dat.id  : '0;
  assign rsp_data  = rsp_valid ? head_dat.dat : '0;
  assign busy      = (outstanding != '0);
endmodule
